// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM download loader.
//   state_e        - loader FSM states
//   DEF_HDR_BYTES  - default copier header length in bytes
//   MIN_MASK       - smallest address mask handed to the mapper (one 16 KiB bank)
//   IOCTL_AW       - width of the download byte offset
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int unsigned DEF_HDR_BYTES = 512;
    localparam int unsigned MIN_MASK      = 'h3FFF;
    localparam int unsigned IOCTL_AW      = 25;

endpackage

// File: rtl/rom_loader_pow2_mask.sv
// pow2_mask: purely combinational mapper mask generator.
//   size_i - byte count of the stored image
//   mask_o - (smallest power of two >= size_i) - 1, never below MIN_MASK
module pow2_mask
    import rom_loader_pkg::*;
#(
    parameter int unsigned W = 22
) (
    input  logic [W-1:0] size_i,
    output logic [W-1:0] mask_o
);

    logic [W-1:0] smear;

    // Smearing (size-1) to the right gives 2^k-1 covering the size; OR with the
    // floor works because both operands are of the form 2^n-1.
    always_comb begin
        smear = (size_i == '0) ? '0 : size_i - W'(1);
        for (int s = 1; s < int'(W); s = s * 2) begin
            smear = smear | (smear >> s);
        end
        mask_o = smear | W'(MIN_MASK);
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: packs the ioctl download byte stream into 16-bit SDRAM writes.
//   clk_sys, reset_n           - clock, synchronous active-low reset
//   ioctl_download/index/wr/addr/dout - download byte stream in
//   ioctl_wait                 - back-pressure while a word write is outstanding
//   mem_req/addr/din/be/ack    - single-outstanding SDRAM write port
//   loading, done              - download in progress / image complete pulse
//   rom_size, rom_mask         - stored byte count and mapper mask
//   ovf                        - sticky dropped-byte flag
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 22,
    parameter logic [5:0]  ROM_INDEX = 6'd1,
    parameter int unsigned HDR_BYTES = DEF_HDR_BYTES
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    output logic                mem_req,
    output logic [ADDR_W-2:0]   mem_addr,
    output logic [15:0]         mem_din,
    output logic [1:0]          mem_be,
    input  logic                mem_ack,
    output logic                loading,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_size,
    output logic [ADDR_W-1:0]   rom_mask,
    output logic                ovf
);

    localparam int unsigned WA_W = ADDR_W - 1;

    state_e              state_q, state_d;
    logic                dl_q;
    logic                hdr_q, hdr_d;
    logic [7:0]          low_q, low_a, low_d;
    logic                low_vld_q, low_vld_a, low_vld_d;
    logic [WA_W-1:0]     low_waddr_q, low_waddr_a, low_waddr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_a, cnt_d, cnt_inc;
    logic                ovf_q, ovf_a, ovf_d;
    logic                req_q, req_a, req_d;
    logic [WA_W-1:0]     addr_q, addr_a, addr_d;
    logic [15:0]         din_q, din_a, din_d;
    logic [1:0]          be_q, be_a, be_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   size_q, size_d;
    logic [ADDR_W-1:0]   mask_q, mask_d;

    logic                dl_rise, dl_fall, hdr_skip, finish_c;
    logic [IOCTL_AW-1:0] ea;
    logic [ADDR_W-1:0]   mask_c;
    logic                idx_unused;

    assign idx_unused = ioctl_index[7];
    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign hdr_skip   = hdr_q && (ioctl_addr < IOCTL_AW'(HDR_BYTES));
    // Saturate so a completely full ROM space still yields an all-ones mask.
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + ADDR_W'(1);

    // Mask is computed from the post-byte count so a byte arriving with the
    // download fall is reflected in the finishing cycle.
    pow2_mask #(.W(ADDR_W)) u_mask (
        .size_i (cnt_a),
        .mask_o (mask_c)
    );

    // Byte intake and write acknowledge; produces the post-byte view (_a).
    always_comb begin
        req_a       = req_q;
        addr_a      = addr_q;
        din_a       = din_q;
        be_a        = be_q;
        low_a       = low_q;
        low_vld_a   = low_vld_q;
        low_waddr_a = low_waddr_q;
        cnt_a       = cnt_q;
        ovf_a       = ovf_q;
        ea          = ioctl_addr - (hdr_q ? IOCTL_AW'(HDR_BYTES) : IOCTL_AW'(0));

        if (req_q && mem_ack) begin
            req_a = 1'b0;
        end

        if (state_q == ST_LOAD && ioctl_wr && !hdr_skip) begin
            if (ea[IOCTL_AW-1:ADDR_W] != '0) begin
                ovf_a = 1'b1;
            end else if (!ea[0]) begin
                low_a       = ioctl_dout;
                low_vld_a   = 1'b1;
                low_waddr_a = ea[ADDR_W-1:1];
                cnt_a       = cnt_inc;
            end else if (req_q) begin
                // Odd byte while a write is still pending: protocol error.
                ovf_a = 1'b1;
            end else begin
                req_a     = 1'b1;
                addr_a    = ea[ADDR_W-1:1];
                din_a     = {ioctl_dout, low_q};
                be_a      = 2'b11;
                low_vld_a = 1'b0;
                cnt_a     = cnt_inc;
            end
        end
    end

    // FSM next state, trailing-byte flush and completion.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        done_d      = 1'b0;
        size_d      = size_q;
        mask_d      = mask_q;
        req_d       = req_a;
        addr_d      = addr_a;
        din_d       = din_a;
        be_d        = be_a;
        low_d       = low_a;
        low_vld_d   = low_vld_a;
        low_waddr_d = low_waddr_a;
        cnt_d       = cnt_a;
        ovf_d       = ovf_a;
        finish_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dl_rise && ioctl_index[5:0] == ROM_INDEX) begin
                    state_d   = ST_LOAD;
                    hdr_d     = ioctl_index[6];
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    low_vld_d = 1'b0;
                    size_d    = '0;
                end
            end
            ST_LOAD: begin
                if (dl_fall) begin
                    if (!req_a && !low_vld_a) begin
                        finish_c = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // A trailing even byte is written only once the bus is idle.
                if (!req_a) begin
                    if (!low_vld_a) begin
                        finish_c = 1'b1;
                    end else if (!req_q) begin
                        req_d     = 1'b1;
                        addr_d    = low_waddr_a;
                        din_d     = {8'h00, low_a};
                        be_d      = 2'b01;
                        low_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            size_d  = cnt_a;
            mask_d  = mask_c;
        end
    end

    // State register; dl_q follows the download line even in reset so a
    // download that stays high across reset is not mistaken for a new one.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dl_q        <= ioctl_download;
            hdr_q       <= 1'b0;
            low_q       <= '0;
            low_vld_q   <= 1'b0;
            low_waddr_q <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            be_q        <= 2'b00;
            done_q      <= 1'b0;
            size_q      <= '0;
            mask_q      <= ADDR_W'(MIN_MASK);
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            hdr_q       <= hdr_d;
            low_q       <= low_d;
            low_vld_q   <= low_vld_d;
            low_waddr_q <= low_waddr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            be_q        <= be_d;
            done_q      <= done_d;
            size_q      <= size_d;
            mask_q      <= mask_d;
        end
    end

    assign ioctl_wait = req_q;
    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign mem_be     = be_q;
    assign loading    = (state_q != ST_IDLE);
    assign done       = done_q;
    assign rom_size   = size_q;
    assign rom_mask   = mask_q;
    assign ovf        = ovf_q;

endmodule
